// File: rtl/sr_seg7_pkg.sv
// Shared definitions for the seven-segment scan driver: hex decode table,
// segment bit positions and a width helper.
package sr_seg7_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Active-high {g,f,e,d,c,b,a} patterns; element index is the nibble value.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic int seg7_clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/sr_seg7_hex2seg.sv
// Combinational nibble to active-high seven-segment decoder; polarity is
// applied by the caller.
module sr_seg7_hex2seg
    import sr_seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    logic [6:0] row;

    assign row = SEG_HEX[nib];

    // Port bit order is tied to the named segment positions, a in bit 0.
    assign seg = {row[SEG_G], row[SEG_F], row[SEG_E], row[SEG_D],
                  row[SEG_C], row[SEG_B], row[SEG_A]};

endmodule

// File: rtl/sr_seg7_scan.sv
// Multiplexed N-digit seven-segment scan driver with blank interval, masks and
// frame-synchronous update. Define SR_SEG7_LZB_EN for leading-zero blanking.
module sr_seg7_scan
    import sr_seg7_pkg::*;
#(
    parameter int DIGITS     = 8,
    parameter int DIV        = 100000,
    parameter int BLANK      = 1000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic [DIGITS-1:0]     digit_en,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame
);

    localparam int PW = seg7_clog2(DIV);
    localparam int IW = (DIGITS > 1) ? seg7_clog2(DIGITS) : 1;
    localparam logic [PW-1:0]     P_LAST  = PW'(DIV - 1);
    localparam logic [IW-1:0]     I_LAST  = IW'(DIGITS - 1);
    localparam logic              POL     = (ACTIVE_LOW != 0);
    localparam logic [6:0]        SEG_OFF = {7{POL}};
    localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{POL}};

    logic [PW-1:0]       p_q, p_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] sh_q, sh_d;
    logic [4*DIGITS-1:0] dr_q, dr_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                frame_q, frame_d;

    logic                latch;
    logic                in_blank;
    logic [3:0]          nib;
    logic                en_cur;
    logic                dpm_cur;
    logic                lzb_cur;
    logic [DIGITS-1:0]   an_sel;
    logic [6:0]          seg_hex;
    logic [6:0]          seg_hi;
    logic                dp_hi;
    logic [DIGITS-1:0]   an_hi;

    generate
        if (BLANK == 0) begin : g_no_blank
            assign in_blank = 1'b0;
        end else begin : g_blank
            assign in_blank = (p_q < PW'(BLANK));
        end
    endgenerate

    // Select the nibble and per-digit controls for the digit being scanned.
    always_comb begin
        nib     = 4'h0;
        en_cur  = 1'b0;
        dpm_cur = 1'b0;
        an_sel  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                nib       = dr_q[4*i +: 4];
                en_cur    = digit_en[i];
                dpm_cur   = dp_mask[i];
                an_sel[i] = 1'b1;
            end
        end
    end

`ifdef SR_SEG7_LZB_EN
    // A digit above 0 is suppressed when it and every digit above it are zero.
    always_comb begin
        lzb_cur = 1'b0;
        for (int i = 1; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) lzb_cur = ((dr_q >> (4*i)) == '0);
        end
    end
`else
    assign lzb_cur = 1'b0;
`endif

    sr_seg7_hex2seg u_hex2seg (
        .nib (nib),
        .seg (seg_hex)
    );

    always_comb begin
        p_d     = (p_q == P_LAST) ? '0 : p_q + 1'b1;
        idx_d   = idx_q;
        if (p_q == P_LAST) idx_d = (idx_q == I_LAST) ? '0 : idx_q + 1'b1;
        latch   = (p_q == P_LAST) && (idx_q == I_LAST);
        sh_d    = load ? value : sh_q;
        dr_d    = latch ? sh_q : dr_q;
        frame_d = latch;
    end

    // Outputs are built active-high, then XOR with the off pattern sets polarity.
    always_comb begin
        seg_hi = 7'h00;
        dp_hi  = 1'b0;
        an_hi  = '0;
        if (!in_blank && en_cur) begin
            if (!lzb_cur) begin
                an_hi  = an_sel;
                seg_hi = seg_hex;
                dp_hi  = dpm_cur;
            end else if (dpm_cur) begin
                an_hi  = an_sel;
                dp_hi  = 1'b1;
            end
        end
        seg_d = seg_hi ^ SEG_OFF;
        dp_d  = dp_hi ^ POL;
        an_d  = an_hi ^ AN_OFF;
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_q     <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            dr_q    <= '0;
            seg_q   <= SEG_OFF;
            dp_q    <= POL;
            an_q    <= AN_OFF;
            frame_q <= 1'b0;
        end else begin
            p_q     <= p_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            dr_q    <= dr_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
            frame_q <= frame_d;
        end
    end

    assign seg   = seg_q;
    assign dp    = dp_q;
    assign an    = an_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_sr_seg7_scan.sv
// Self-checking bench for sr_seg7_scan: cycle-count reference model plus
// directed scenarios with hand-computed expectations.
module tb_sr_seg7_scan;

    localparam int DIGITS     = 8;
    localparam int DIV        = 4;
    localparam int BLANK      = 1;
    localparam int ACTIVE_LOW = 1;
    localparam int FRAME_LEN  = DIV * DIGITS;

`ifdef SR_SEG7_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] value;
    logic        load;
    logic [7:0]  dp_mask;
    logic [7:0]  digit_en;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  an;
    logic        frame;

    sr_seg7_scan #(
        .DIGITS     (DIGITS),
        .DIV        (DIV),
        .BLANK      (BLANK),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .value    (value),
        .load     (load),
        .dp_mask  (dp_mask),
        .digit_en (digit_en),
        .seg      (seg),
        .dp       (dp),
        .an       (an),
        .frame    (frame)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the slot position follows from the number of cycles
    // since reset; the display value changes only at frame boundaries.
    logic [6:0]  dec [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int          m_t;
    logic [31:0] m_sh, m_dr;
    logic [7:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp, exp_frame;
    bit          model_valid = 1'b0;
    logic        pol;

    initial begin
        pol = (ACTIVE_LOW != 0);
        forever begin
            int         sp, si;
            logic [3:0] mnib;
            bit         lzb;
            logic [7:0] hi_an;
            logic [6:0] hi_seg;
            logic       hi_dp;
            @(posedge clk);
            hi_an  = '0;
            hi_seg = '0;
            hi_dp  = 1'b0;
            if (!rst_n) begin
                m_t       = 0;
                m_sh      = '0;
                m_dr      = '0;
                exp_frame = 1'b0;
            end else begin
                sp = m_t % DIV;
                si = (m_t / DIV) % DIGITS;
                if (sp >= BLANK && digit_en[si]) begin
                    mnib = 4'(m_dr >> (4*si));
                    lzb  = LZB && (si > 0) && ((m_dr >> (4*si)) == 0);
                    if (!lzb) begin
                        hi_an  = 8'(1 << si);
                        hi_seg = dec[mnib];
                        hi_dp  = dp_mask[si];
                    end else if (dp_mask[si]) begin
                        hi_an  = 8'(1 << si);
                        hi_dp  = 1'b1;
                    end
                end
                exp_frame = ((m_t % FRAME_LEN) == FRAME_LEN - 1);
                if (exp_frame) m_dr = m_sh;
                if (load) m_sh = value;
                m_t++;
            end
            exp_an      = hi_an ^ {8{pol}};
            exp_seg     = hi_seg ^ {7{pol}};
            exp_dp      = hi_dp ^ pol;
            model_valid = 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (model_valid) begin
                check("model_an", an, exp_an);
                check("model_seg", seg, exp_seg);
                check("model_dp", dp, exp_dp);
                check("model_frame", frame, exp_frame);
                check("onehot_an", 32'($countones(~an) <= 1), 1);
            end
        end
    end

    int         cnt [DIGITS];
    logic [6:0] seg_at [DIGITS];

    task automatic wait_frame(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame !== 1'b1 && n < 200);
        check(name, frame, 1);
    endtask

    task automatic wait_an(input logic [7:0] pat, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (an !== pat && n < 200);
        check(name, an, pat);
    endtask

    task automatic count_frame();
        for (int i = 0; i < DIGITS; i++) begin
            cnt[i]    = 0;
            seg_at[i] = 7'h00;
        end
        repeat (FRAME_LEN) begin
            @(negedge clk);
            for (int i = 0; i < DIGITS; i++) begin
                if (an === ~(8'd1 << i)) begin
                    cnt[i]++;
                    seg_at[i] = seg;
                end
            end
        end
    endtask

    task automatic scan_lit(input int n, input logic [6:0] exp, input string name);
        repeat (n) begin
            @(negedge clk);
            if (an !== 8'hFF) check(name, seg, exp);
        end
    endtask

    initial begin
        int hold_n, t0, t2, c0, c1;
        rst_n    = 1'b0;
        value    = '0;
        load     = 1'b0;
        dp_mask  = 8'h00;
        digit_en = 8'hFF;

        repeat (4) begin
            @(negedge clk);
            check("rst_an", an, 8'hFF);
            check("rst_seg", seg, 7'h7F);
            check("rst_dp", dp, 1);
            check("rst_frame", frame, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("first_blank_an", an, 8'hFF);
        @(negedge clk);
        check("first_lit_an", an, 8'hFE);
        check("first_lit_seg", seg, 7'h40);

        // Scan order with distinct digits.
        value = 32'h76543210;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_frame("frame_scan");
        count_frame();
        for (int i = 0; i < DIGITS; i++) check($sformatf("scan_cnt_%0d", i), cnt[i], 3);
        check("digit0_seg", seg_at[0], 7'h40);
        check("digit3_seg", seg_at[3], 7'h30);
        check("digit7_seg", seg_at[7], 7'h78);

        // Tear-free update: a mid-frame load waits for the frame boundary.
        value = 32'h11111111;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_frame("frame_ones");
        wait_an(8'hEF, "reach_idx4");
        value = 32'hFFFFFFFF;
        load  = 1'b1;
        @(negedge clk);
        load   = 1'b0;
        hold_n = 0;
        do begin
            if (an !== 8'hFF) check("hold_ones_seg", seg, 7'h79);
            @(negedge clk);
            hold_n++;
        end while (frame !== 1'b1 && hold_n < 64);
        if (an !== 8'hFF) check("hold_ones_seg", seg, 7'h79);
        check("frame_after_mid_load", frame, 1);

        // A load on the latch edge itself shows one frame later.
        scan_lit(30, 7'h0E, "show_f_seg");
        @(negedge clk);
        if (an !== 8'hFF) check("show_f_seg", seg, 7'h0E);
        value = 32'h22222222;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("coincident_frame", frame, 1);
        if (an !== 8'hFF) check("coincident_old_seg", seg, 7'h0E);
        scan_lit(31, 7'h0E, "coincident_hold_seg");
        @(negedge clk);
        check("frame_two", frame, 1);
        scan_lit(32, 7'h24, "show_two_seg");
        check("frame_masks", frame, 1);

        // Masks: digit 1 disabled, decimal point on digit 0 only.
        digit_en = 8'hFD;
        dp_mask  = 8'h01;
        t0 = -1;
        t2 = -1;
        c0 = 0;
        c1 = 0;
        for (int k = 1; k <= FRAME_LEN; k++) begin
            @(negedge clk);
            if (an === 8'hFE) begin
                c0++;
                if (t0 < 0) t0 = k;
                check("dp_digit0", dp, 0);
            end else if (an !== 8'hFF) begin
                check("dp_other", dp, 1);
            end
            if (an === 8'hFD) c1++;
            if (an === 8'hFB && t2 < 0) t2 = k;
        end
        check("digit1_never", c1, 0);
        check("digit0_count", c0, 3);
        check("slot_spacing", t2 - t0, 8);

        // Leading zeros.
        digit_en = 8'hFF;
        dp_mask  = 8'h00;
        value    = 32'h00000A05;
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_frame("frame_a05");
        count_frame();
        for (int i = 0; i < DIGITS; i++)
            check($sformatf("a05_cnt_%0d", i), cnt[i], (LZB && i > 2) ? 0 : 3);
        check("a05_digit2_seg", seg_at[2], 7'h08);
        value = 32'h00000000;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_frame("frame_zero");
        count_frame();
        for (int i = 0; i < DIGITS; i++)
            check($sformatf("zero_cnt_%0d", i), cnt[i], (LZB && i > 0) ? 0 : 3);
        check("zero_digit0_seg", seg_at[0], 7'h40);

        // Reset in the middle of slot 5.
        value = 32'h76543210;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_frame("frame_pre_reset");
        wait_an(8'hDF, "reach_idx5");
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_an", an, 8'hFF);
        check("midrst_seg", seg, 7'h7F);
        check("midrst_dp", dp, 1);
        check("midrst_frame", frame, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_blank_an", an, 8'hFF);
        @(negedge clk);
        check("midrst_lit_an", an, 8'hFE);
        check("midrst_dr_cleared_seg", seg, 7'h40);
        repeat (40) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: run did not finish, %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
